// File: rtl/ace_if.sv
// ----------------------------------------------------------------------------
// ace_if : ACE channel bundle between one ACE master and one ACE slave.
//
// Carries the AXI core channels (AW, W, B, AR, R), the ACE read response
// extension (RRESP[3:2]), the snoop channels (AC, CR, CD) and the RACK/WACK
// acknowledge lines.
//   modport m : master side (drives AW/W/AR requests, B/R readies, CR/CD,
//               rack, wack)
//   modport s : slave side  (drives AW/W/AR readies, B/R responses, AC,
//               CR/CD readies)
// ----------------------------------------------------------------------------
interface ace_if #(
  parameter int ACE_ADDR_WIDTH = 32,
  parameter int ACE_DATA_WIDTH = 32,
  parameter int ACE_ID_WIDTH   = 4,
  parameter int ACE_USER_WIDTH = 1
) ();

  // AW
  logic [ACE_ID_WIDTH-1:0]     awid;
  logic [ACE_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  // W
  logic [ACE_DATA_WIDTH-1:0]   wdata;
  logic [ACE_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  // B
  logic [ACE_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;
  logic [ACE_USER_WIDTH-1:0]   buser;
  logic                        bvalid;
  logic                        bready;
  // AR
  logic [ACE_ID_WIDTH-1:0]     arid;
  logic [ACE_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  // R
  logic [ACE_ID_WIDTH-1:0]     rid;
  logic [ACE_DATA_WIDTH-1:0]   rdata;
  logic [3:0]                  rresp;
  logic                        rlast;
  logic [ACE_USER_WIDTH-1:0]   ruser;
  logic                        rvalid;
  logic                        rready;
  // AC
  logic                        acvalid;
  logic                        acready;
  logic [ACE_ADDR_WIDTH-1:0]   acaddr;
  logic [3:0]                  acsnoop;
  logic [2:0]                  acprot;
  // CR
  logic                        crvalid;
  logic                        crready;
  logic [4:0]                  crresp;
  // CD
  logic                        cdvalid;
  logic                        cdready;
  logic [ACE_DATA_WIDTH-1:0]   cddata;
  logic                        cdlast;
  // Acknowledges
  logic                        rack;
  logic                        wack;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready,
    input  acvalid, acaddr, acsnoop, acprot,
    output acready,
    output crvalid, crresp,
    input  crready,
    output cdvalid, cddata, cdlast,
    input  cdready,
    output rack, wack
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready,
    output acvalid, acaddr, acsnoop, acprot,
    input  acready,
    input  crvalid, crresp,
    output crready,
    input  cdvalid, cddata, cdlast,
    output cdready,
    input  rack, wack
  );

endinterface

// File: rtl/ace_mem_slave.sv
// ----------------------------------------------------------------------------
// ace_mem_slave : single-beat ACE slave memory.
//
// Serves reads (AR->R, completed by RACK) and writes (AW->W->B, completed by
// WACK) from an internal word array. One transaction in flight at a time; a
// registered select pointer arbitrates when AR and AW arrive together and
// toggles after every completed transaction. Never issues snoops.
//
// Ports
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset (memory array is not reset)
//   ace    : ace_if.s slave side
//
// Parameters
//   ACE_ADDR_WIDTH / ACE_DATA_WIDTH : must match the connected ace_if
//   DEPTH        : number of data words (power of two, >= 2)
//   BASE_ADDR    : byte address of word 0, aligned to the array span
//   READ_LATENCY : AR handshake to rvalid, in cycles (1..15)
// ----------------------------------------------------------------------------
module ace_mem_slave #(
  parameter int                        ACE_ADDR_WIDTH = 32,
  parameter int                        ACE_DATA_WIDTH = 32,
  parameter int                        DEPTH          = 1024,
  parameter logic [ACE_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        READ_LATENCY   = 1
) (
  input  logic clk,
  input  logic rst_n,
  ace_if.s     ace
);

  localparam int BYTES = ACE_DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ACE_ADDR_WIDTH:0] SPAN = (ACE_ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_WAIT, ST_RD_RESP, ST_RD_ACK, ST_WR_DATA, ST_WR_RESP, ST_WR_ACK
  } state_e;

  typedef enum logic {SEL_READ, SEL_WRITE} sel_e;

  // Offset from BASE_ADDR; out-of-range addresses wrap to large values.
  function automatic logic in_span(input logic [ACE_ADDR_WIDTH-1:0] off);
    return {1'b0, off} < SPAN;
  endfunction

  logic [ACE_DATA_WIDTH-1:0] mem [DEPTH];

  state_e                    state_q, state_d;
  sel_e                      sel_q, sel_d;
  logic                      idle_rdy_q, idle_rdy_d;
  logic [ACE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic [ACE_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic                      ar_grant, aw_grant, wr_en;
  logic [ACE_ADDR_WIDTH-1:0] ar_off, cur_off;
  logic                      ar_hit, cur_hit;
  logic [IDX_W-1:0]          ar_idx, cur_idx;
  logic [ACE_DATA_WIDTH-1:0] ar_word, cur_word;

  // Offsets for the incoming AR address (zero-latency path) and the latched one.
  assign ar_off   = ace.araddr - BASE_ADDR;
  assign cur_off  = addr_q - BASE_ADDR;
  assign ar_hit   = in_span(ar_off);
  assign cur_hit  = in_span(cur_off);
  assign ar_idx   = ar_off[IDX_W+OFS_W-1:OFS_W];
  assign cur_idx  = cur_off[IDX_W+OFS_W-1:OFS_W];
  assign ar_word  = mem[ar_idx];
  assign cur_word = mem[cur_idx];

  // idle_rdy_q is registered, so readies only depend on the valids through the
  // pointer-based tie break when both channels request at once.
  assign ar_grant = idle_rdy_q && (!ace.awvalid || sel_q == SEL_READ);
  assign aw_grant = idle_rdy_q && (!ace.arvalid || sel_q == SEL_WRITE);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    wr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ar_grant && ace.arvalid) begin
          addr_d = ace.araddr;
          if (READ_LATENCY == 1) begin
            state_d  = ST_RD_RESP;
            rvalid_d = 1'b1;
            rdata_d  = ar_hit ? ar_word : '0;
            rresp_d  = ar_hit ? RESP_OKAY : RESP_DECERR;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = LAT_M1;
          end
        end else if (aw_grant && ace.awvalid) begin
          addr_d  = ace.awaddr;
          state_d = ST_WR_DATA;
        end
      end

      ST_RD_WAIT: begin
        // The array is sampled on the cycle rvalid rises, so a write that
        // completed earlier is always visible.
        if (cnt_q <= 4'd1) begin
          state_d  = ST_RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = cur_hit ? cur_word : '0;
          rresp_d  = cur_hit ? RESP_OKAY : RESP_DECERR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RD_RESP: begin
        if (ace.rready) begin
          rvalid_d = 1'b0;
          rdata_d  = '0;
          rresp_d  = RESP_OKAY;
          if (ace.rack) begin
            state_d = ST_IDLE;
            sel_d   = (sel_q == SEL_READ) ? SEL_WRITE : SEL_READ;
          end else begin
            state_d = ST_RD_ACK;
          end
        end
      end

      ST_RD_ACK: begin
        if (ace.rack) begin
          state_d = ST_IDLE;
          sel_d   = (sel_q == SEL_READ) ? SEL_WRITE : SEL_READ;
        end
      end

      ST_WR_DATA: begin
        if (ace.wvalid) begin
          wr_en    = cur_hit;
          bvalid_d = 1'b1;
          bresp_d  = cur_hit ? RESP_OKAY : RESP_DECERR;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (ace.bready) begin
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          if (ace.wack) begin
            state_d = ST_IDLE;
            sel_d   = (sel_q == SEL_READ) ? SEL_WRITE : SEL_READ;
          end else begin
            state_d = ST_WR_ACK;
          end
        end
      end

      ST_WR_ACK: begin
        if (ace.wack) begin
          state_d = ST_IDLE;
          sel_d   = (sel_q == SEL_READ) ? SEL_WRITE : SEL_READ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    idle_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_READ;
      idle_rdy_q <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idle_rdy_q <= idle_rdy_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Memory contents survive reset; a completed W handshake stays committed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (ace.wstrb[b]) begin
          mem[cur_idx][8*b +: 8] <= ace.wdata[8*b +: 8];
        end
      end
    end
  end

  assign ace.awready = aw_grant;
  assign ace.arready = ar_grant;
  assign ace.wready  = (state_q == ST_WR_DATA);
  assign ace.bvalid  = bvalid_q;
  assign ace.bresp   = bresp_q;
  assign ace.bid     = '0;
  assign ace.buser   = '0;
  assign ace.rvalid  = rvalid_q;
  assign ace.rdata   = rdata_q;
  assign ace.rresp   = {2'b00, rresp_q};
  assign ace.rlast   = rvalid_q;
  assign ace.rid     = '0;
  assign ace.ruser   = '0;
  assign ace.acvalid = 1'b0;
  assign ace.acaddr  = '0;
  assign ace.acsnoop = '0;
  assign ace.acprot  = '0;
  assign ace.crready = 1'b1;
  assign ace.cdready = 1'b1;

  // Burst/ID attributes and snoop responses carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{ace.awid, ace.awlen, ace.awsize, ace.awburst,
                           ace.arid, ace.arlen, ace.arsize, ace.arburst,
                           ace.wlast, ace.acready, ace.crvalid, ace.crresp,
                           ace.cdvalid, ace.cddata, ace.cdlast};

endmodule
